vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical equivalents, in lines.
REQ-006 SHALL have parameter HS_POL, default 0: hsync active level. VS_POL, default 0: vsync active level.
REQ-007 SHALL have parameter CNT_W, default 10: counter width. FRAME_W, default 8: frame counter width.
REQ-008 SHALL have ports:
  - clock  in  1  pixel clock, the only clock.
  - reset  in  1  asynchronous, active-high.
  - pixel_en  in  1  pixel clock enable.
  - hsync, vsync  out  1  sync outputs, at the levels set by HS_POL/VS_POL.
  - de  out  1  active-area data enable.
  - hcount, vcount  out  CNT_W  position on the current line (hcount) and in the current frame (vcount).
  - x, y  out  CNT_W  active-area coordinates; 0 outside the active area.
  - sol, eol, sof, eof  out  1  single-cycle strobes: start of line, end of line, start of frame, end of frame.
  - frame_cnt  out  FRAME_W  completed-frame counter.

Function
REQ-009 SHALL order each line as: active, front porch, sync, back porch. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. Vertical SHALL use the same order, giving V_TOTAL.
REQ-010 SHALL keep internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1).
REQ-011 SHALL advance the counters only on clock edges where pixel_en=1. With pixel_en=0, every counter and output SHALL hold, except the strobes.
REQ-012 SHALL wrap hc from H_TOTAL-1 to 0. On that same edge vc SHALL increment, and wrap from V_TOTAL-1 to 0.
REQ-013 SHALL register all outputs. On each pixel_en edge, outputs SHALL take the decode of the pre-edge (hc,vc), so outputs lag the internal counters by one enabled cycle.
REQ-014 SHALL set de=1 when hc<H_ACTIVE and vc<V_ACTIVE. In that case x=hc and y=vc; otherwise x=0 and y=0.
REQ-015 SHALL drive hsync=HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise. vsync SHALL follow the same rule using vc, V_* and VS_POL.
REQ-016 SHALL assert the strobes when, respectively: sol at hc=0; eol at hc=H_ACTIVE-1; sof at (0,0); eof at (H_ACTIVE-1, V_ACTIVE-1). Each strobe SHALL be high for exactly one clock and be cleared on any edge with pixel_en=0.
REQ-017 SHALL increment frame_cnt, modulo 2^FRAME_W, on the enabled edge where hc=H_TOTAL-1 and vc=V_TOTAL-1.
REQ-018 SHALL have hcount/vcount equal the decoded (hc,vc), consistent in the same cycle as de, sync and the strobes.
REQ-019 SHALL reject at elaboration any configuration where H_TOTAL or V_TOTAL exceeds 2^CNT_W, or any of the eight timing parameters is 0.

Reset
REQ-020 SHALL, while reset=1 and regardless of clock or pixel_en, immediately force:
  - hc=vc=0, hcount=vcount=0, x=y=0;
  - de=0, all strobes 0, frame_cnt=0;
  - hsync=~HS_POL, vsync=~VS_POL.
REQ-021 SHALL, on the first enabled edge after reset deassertion, output (0,0) with de=1, sol=1, sof=1. Reset mid-frame SHALL restart the frame from (0,0).

Structure
REQ-022 SHALL take its timing-set constants from shared package vga_timing_pkg: 640x480@60 (25 MHz) and 800x600@60 (40 MHz) H/V parameter sets.
REQ-023 SHALL instantiate sub-module vga_axis_cnt twice, once horizontal and once vertical. Each instance is a parametrised wrap counter with active/sync phase decode, enable input and terminal-count output.

Verification
REQ-024 SHALL cover, with default parameters:
  - Reset with pixel_en=1, then release: during reset hsync=vsync=1 and de=0; first edge after release gives de=1, x=0, y=0, sof=sol=1.
  - Full line: de high for hcount 0..639, eol at 639; hsync low exactly for hcount 656..751 (96 cycles); hcount 799 followed by 0 with vcount+1.
  - Full frame: vsync low for vcount 490..491; eof at (639,479); frame_cnt 0->1 after (799,524); then sof again at (0,0).
  - pixel_en alternating 1/0: counters advance every second clock; strobes are exactly 1 clock wide; outputs hold on disabled cycles.
  - Reset asserted at (300,200): all outputs go to reset values immediately; the first enabled edge after release outputs (0,0).
  - HS_POL=1 and VS_POL=1 with the vga_timing_pkg 800x600 set: hsync high for hcount 840..967; vsync high for vcount 601..604.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing sets and helpers for the timing generator.
package vga_timing_pkg;

  // One axis of a video mode, in pixels (horizontal) or lines (vertical).
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  // 640x480@60, 25 MHz pixel clock.
  localparam axis_timing_t VGA640_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam axis_timing_t VGA640_V = '{active: 480, fp: 10, sync: 2,   bp: 33};

  // 800x600@60, 40 MHz pixel clock.
  localparam axis_timing_t VGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_timing_t VGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  // Full period of one axis: active + front porch + sync + back porch.
  function automatic int unsigned axis_total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// Wrapping position counter for one video axis with phase decode.
module vga_axis_cnt #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             active_c,
  output logic             sync_c,
  output logic             first_c,
  output logic             last_active_c,
  output logic             last_c
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  // Every boundary below TOTAL fits in CNT_W once the top-level range check holds.
  localparam logic [CNT_W-1:0] LAST_POS    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END     = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] ACT_LAST    = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END    = CNT_W'(ACTIVE + FP + SYNC);

  // Phase decode of the current position.
  always_comb begin
    active_c      = (cnt < ACT_END);
    sync_c        = (cnt >= SYNC_START) && (cnt < SYNC_END);
    first_c       = (cnt == '0);
    last_active_c = (cnt == ACT_LAST);
    last_c        = (cnt == LAST_POS);
  end

  // Position counter: advances on step, wraps after the back porch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/position generator: two axis counters plus a registered output stage.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H.active,
  parameter int unsigned H_FP     = VGA640_H.fp,
  parameter int unsigned H_SYNC   = VGA640_H.sync,
  parameter int unsigned H_BP     = VGA640_H.bp,
  parameter int unsigned V_ACTIVE = VGA640_V.active,
  parameter int unsigned V_FP     = VGA640_V.fp,
  parameter int unsigned V_SYNC   = VGA640_V.sync,
  parameter int unsigned V_BP     = VGA640_V.bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pixel_en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               sol,
  output logic               eol,
  output logic               sof,
  output logic               eof,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam axis_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam axis_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned H_TOTAL = axis_total(H_T);
  localparam int unsigned V_TOTAL = axis_total(V_T);

  // Refuse configurations whose counters cannot hold a full period.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("vga_timing_gen: zero timing parameter or total exceeds 2**CNT_W");
  end

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic h_active_c, h_sync_c, h_first_c, h_last_active_c, h_last_c;
  logic v_active_c, v_sync_c, v_first_c, v_last_active_c, v_last_c;
  logic v_step_c;
  logic de_c;

  // Line advances once per enabled pixel at the end of each line.
  assign v_step_c = pixel_en & h_last_c;
  assign de_c     = h_active_c & v_active_c;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_cnt (
    .clock         (clock),
    .reset         (reset),
    .step          (pixel_en),
    .cnt           (hc),
    .active_c      (h_active_c),
    .sync_c        (h_sync_c),
    .first_c       (h_first_c),
    .last_active_c (h_last_active_c),
    .last_c        (h_last_c)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_cnt (
    .clock         (clock),
    .reset         (reset),
    .step          (v_step_c),
    .cnt           (vc),
    .active_c      (v_active_c),
    .sync_c        (v_sync_c),
    .first_c       (v_first_c),
    .last_active_c (v_last_active_c),
    .last_c        (v_last_c)
  );

  // Level outputs: capture the pre-edge position decode on enabled edges, hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
      x      <= '0;
      y      <= '0;
      de     <= 1'b0;
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
    end else if (pixel_en) begin
      hcount <= hc;
      vcount <= vc;
      x      <= de_c ? hc : '0;
      y      <= de_c ? vc : '0;
      de     <= de_c;
      hsync  <= h_sync_c ? HS_POL : ~HS_POL;
      vsync  <= v_sync_c ? VS_POL : ~VS_POL;
    end
  end

  // Strobes: one clock wide, forced low on every disabled edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sol <= 1'b0;
      eol <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
    end else begin
      sol <= pixel_en & h_first_c;
      eol <= pixel_en & h_last_active_c;
      sof <= pixel_en & h_first_c & v_first_c;
      eof <= pixel_en & h_last_active_c & v_last_active_c;
    end
  end

  // Completed-frame counter, bumped as the last position of the frame is left.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (pixel_en && h_last_c && v_last_c) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three configurations against a closed-form timing model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pixel_en = 1'b1;

  // Default 640x480, active-low syncs.
  logic a_hsync, a_vsync, a_de, a_sol, a_eol, a_sof, a_eof;
  logic [9:0] a_hcount, a_vcount, a_x, a_y;
  logic [7:0] a_frame;
  // 800x600 from the package, active-high syncs.
  logic b_hsync, b_vsync, b_de, b_sol, b_eol, b_sof, b_eof;
  logic [10:0] b_hcount, b_vcount, b_x, b_y;
  logic [7:0] b_frame;
  // Tiny mode so whole frames and frame counter wrap fit in the run.
  logic c_hsync, c_vsync, c_de, c_sol, c_eol, c_sof, c_eof;
  logic [3:0] c_hcount, c_vcount, c_x, c_y;
  logic [1:0] c_frame;

  int n_tests = 0;
  int n_fail  = 0;
  int n_steps = 0;   // enabled edges since reset release
  bit last_en = 1'b0;

  always #5 clock = ~clock;

  vga_timing_gen dut640 (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .hcount(a_hcount), .vcount(a_vcount), .x(a_x), .y(a_y),
    .sol(a_sol), .eol(a_eol), .sof(a_sof), .eof(a_eof), .frame_cnt(a_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(VGA800_H.active), .H_FP(VGA800_H.fp), .H_SYNC(VGA800_H.sync), .H_BP(VGA800_H.bp),
    .V_ACTIVE(VGA800_V.active), .V_FP(VGA800_V.fp), .V_SYNC(VGA800_V.sync), .V_BP(VGA800_V.bp),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11), .FRAME_W(8)
  ) dut800 (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .hcount(b_hcount), .vcount(b_vcount), .x(b_x), .y(b_y),
    .sol(b_sol), .eol(b_eol), .sof(b_sof), .eof(b_eof), .frame_cnt(b_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(4), .FRAME_W(2)
  ) dut_tiny (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .hsync(c_hsync), .vsync(c_vsync), .de(c_de),
    .hcount(c_hcount), .vcount(c_vcount), .x(c_x), .y(c_y),
    .sol(c_sol), .eol(c_eol), .sof(c_sof), .eof(c_eof), .frame_cnt(c_frame)
  );

  task automatic check_eq(input string tag, input logic [58:0] got, input logic [58:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (n=%0d)", tag, got, exp, n_steps);
    end
  endtask

  // Common packing of one DUT's outputs: frame, hcount, vcount, x, y, hs, vs, de, sol, eol, sof, eof.
  function automatic logic [58:0] pk(input int unsigned fr, input int unsigned hcnt,
                                     input int unsigned vcnt, input int unsigned xx,
                                     input int unsigned yy, input logic hsy, input logic vsy,
                                     input logic d, input logic s1, input logic e1,
                                     input logic s2, input logic e2);
    return {8'(fr), 11'(hcnt), 11'(vcnt), 11'(xx), 11'(yy), hsy, vsy, d, s1, e1, s2, e2};
  endfunction

  // After n enabled edges, outputs show position n-1 of the raster scan.
  function automatic logic [58:0] model(input int n, input bit en,
                                        input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb,
                                        input bit hp, input bit vp, input int fw);
    int ht, vt, fr_len, p, hc, vc;
    bit d;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    fr_len = ht * vt;
    if (n == 0) return pk(0, 0, 0, 0, 0, ~hp, ~vp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    p  = (n - 1) % fr_len;
    hc = p % ht;
    vc = p / ht;
    d  = (hc < ha) && (vc < va);
    return pk((n / fr_len) % (1 << fw), hc, vc, d ? hc : 0, d ? vc : 0,
              (hc >= ha + hf && hc < ha + hf + hs) ? hp : ~hp,
              (vc >= va + vf && vc < va + vf + vs) ? vp : ~vp,
              d, en && hc == 0, en && hc == ha - 1,
              en && hc == 0 && vc == 0, en && hc == ha - 1 && vc == va - 1);
  endfunction

  task automatic compare_all();
    check_eq("dut640", pk(a_frame, a_hcount, a_vcount, a_x, a_y, a_hsync, a_vsync, a_de,
                          a_sol, a_eol, a_sof, a_eof),
             model(n_steps, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8));
    check_eq("dut800", pk(b_frame, b_hcount, b_vcount, b_x, b_y, b_hsync, b_vsync, b_de,
                          b_sol, b_eol, b_sof, b_eof),
             model(n_steps, last_en, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 8));
    check_eq("dut_tiny", pk(c_frame, c_hcount, c_vcount, c_x, c_y, c_hsync, c_vsync, c_de,
                            c_sol, c_eol, c_sof, c_eof),
             model(n_steps, last_en, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b1, 2));
  endtask

  // Drive pixel_en for the next rising edge, advance the model, compare on the falling edge.
  task automatic step(input bit en);
    pixel_en = en;
    if (reset) begin
      n_steps = 0;
      last_en = 1'b0;
    end else begin
      if (en) n_steps++;
      last_en = en;
    end
    @(negedge clock);
    compare_all();
  endtask

  int hs_low_cnt, hs_first, hs_last, de_cnt, eol_h, b_hs_cnt, b_hs_first;
  bit found;

  initial begin
    // Reset held with the enable active and the clock running.
    for (int i = 0; i < 5; i++) step(1'b1);
    check_eq("rst_hs_vs_de", {a_hsync, a_vsync, a_de}, 3'b110);

    // Release and run the first lines with a continuous enable.
    reset = 1'b0;
    hs_low_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; eol_h = -1;
    b_hs_cnt = 0; b_hs_first = -1;
    for (int i = 1; i <= 2200; i++) begin
      step(1'b1);
      if (i == 1) begin
        check_eq("first_edge", {a_de, 10'(a_x), 10'(a_y), a_sof, a_sol}, {1'b1, 20'd0, 2'b11});
      end
      if (i <= 800) begin
        if (!a_hsync) begin
          hs_low_cnt++;
          if (hs_first < 0) hs_first = int'(a_hcount);
          hs_last = int'(a_hcount);
        end
        if (a_de) de_cnt++;
        if (a_eol && eol_h < 0) eol_h = int'(a_hcount);
      end
      if (i <= 1056 && b_hsync) begin
        b_hs_cnt++;
        if (b_hs_first < 0) b_hs_first = int'(b_hcount);
      end
      if (i == 800) check_eq("line_end", {10'(a_hcount), 10'(a_vcount)}, {10'd799, 10'd0});
      if (i == 801) check_eq("line_wrap", {10'(a_hcount), 10'(a_vcount)}, {10'd0, 10'd1});
    end
    check_eq("hs_low_width", 59'(hs_low_cnt), 59'd96);
    check_eq("hs_low_first", 59'(hs_first), 59'd656);
    check_eq("hs_low_last", 59'(hs_last), 59'd751);
    check_eq("de_width", 59'(de_cnt), 59'd640);
    check_eq("eol_hcount", 59'(eol_h), 59'd639);
    check_eq("hs800_width", 59'(b_hs_cnt), 59'd128);
    check_eq("hs800_first", 59'(b_hs_first), 59'd840);

    // Alternating enable, then random enable.
    for (int i = 0; i < 2000; i++) step(i % 2 == 0);
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0);

    // Reach hcount 300 on the default mode, then reset asynchronously mid-cycle.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step(1'b1);
      if (a_hcount == 10'd300) found = 1'b1;
    end
    check_eq("find_h300", 59'(found), 59'd1);
    #2 reset = 1'b1;
    n_steps = 0;
    last_en = 1'b0;
    #1 compare_all();
    @(negedge clock);
    for (int i = 0; i < 3; i++) step(1'b1);

    // Release and run a long randomized stretch covering many tiny frames.
    reset = 1'b0;
    step(1'b1);
    check_eq("restart_00", {10'(a_hcount), 10'(a_vcount), a_de, a_sof}, {20'd0, 2'b11});
    for (int i = 0; i < 30000; i++) step($urandom_range(0, 7) != 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
